// File: rtl/izh_pkg.sv
// Shared definitions for the Izhikevich neuron array.
// Holds the sweep FSM state enum, Q15.16 fixed-point constants, the
// default neuron parameters and reset state, and saturating add/sub helpers.
package izh_pkg;

  localparam int unsigned IZH_N    = 32;
  localparam int unsigned IZH_FRAC = 16;

  typedef logic signed [IZH_N-1:0] fx_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CALC,
    S_UPDATE,
    S_EMIT,
    S_DONE
  } state_t;

  localparam fx_t FX_MAX = fx_t'({1'b0, {(IZH_N-1){1'b1}}});
  localparam fx_t FX_MIN = fx_t'({1'b1, {(IZH_N-1){1'b0}}});

  // Model coefficients in Q15.16
  localparam fx_t K_0P04 = fx_t'(32'h0000_0A3D);
  localparam fx_t K_5    = fx_t'(32'h0005_0000);
  localparam fx_t K_140  = fx_t'(32'h008C_0000);

  // Default a/b/c/d (0.02, 0.2, -65, 5)
  localparam fx_t A_DEF = fx_t'(32'h0000_051F);
  localparam fx_t B_DEF = fx_t'(32'h0000_3333);
  localparam fx_t C_DEF = fx_t'(32'hFFBF_0000);
  localparam fx_t D_DEF = fx_t'(32'h0005_0000);

  // Reset state: v = -65, w = -13
  localparam fx_t V_RST = fx_t'(32'hFFBF_0000);
  localparam fx_t W_RST = fx_t'(32'hFFF3_0000);

  // Saturating a + b
  function automatic fx_t sat_add(input fx_t a, input fx_t b);
    logic signed [IZH_N:0] s;
    s = (IZH_N+1)'(a) + (IZH_N+1)'(b);
    if (s[IZH_N] != s[IZH_N-1]) return s[IZH_N] ? FX_MIN : FX_MAX;
    return fx_t'(s[IZH_N-1:0]);
  endfunction

  // Saturating a - b
  function automatic fx_t sat_sub(input fx_t a, input fx_t b);
    logic signed [IZH_N:0] s;
    s = (IZH_N+1)'(a) - (IZH_N+1)'(b);
    if (s[IZH_N] != s[IZH_N-1]) return s[IZH_N] ? FX_MIN : FX_MAX;
    return fx_t'(s[IZH_N-1:0]);
  endfunction

endpackage

// File: rtl/izh_datapath.sv
// Combinational single-neuron Euler step of the Izhikevich model.
// Ports:
//   i_v, i_w        current membrane state
//   i_cur           input current I
//   i_a..i_d        neuron parameters a, b, c, d
//   o_v_new_c       v to write back (c if the neuron fires)
//   o_w_new_c       w to write back (w + d if the neuron fires)
//   o_fire_c        v_tmp strictly above V_TH
module izh_datapath
  import izh_pkg::*;
#(
  parameter int unsigned       DT_SHIFT = 3,
  parameter logic signed [IZH_N-1:0] V_TH = 32'sh0020_0000
) (
  input  logic signed [IZH_N-1:0] i_v,
  input  logic signed [IZH_N-1:0] i_w,
  input  logic signed [IZH_N-1:0] i_cur,
  input  logic signed [IZH_N-1:0] i_a,
  input  logic signed [IZH_N-1:0] i_b,
  input  logic signed [IZH_N-1:0] i_c,
  input  logic signed [IZH_N-1:0] i_d,
  output logic signed [IZH_N-1:0] o_v_new_c,
  output logic signed [IZH_N-1:0] o_w_new_c,
  output logic                    o_fire_c
);

  // Full-width signed product, floor-scaled back to Q15.16, then clamped
  function automatic fx_t sat_mul(input fx_t x, input fx_t y);
    logic signed [2*IZH_N-1:0] p;
    logic        [IZH_N:0]     hi;
    p  = (2*IZH_N)'(x) * (2*IZH_N)'(y);
    p  = p >>> IZH_FRAC;
    hi = p[2*IZH_N-1:IZH_N-1];
    if (hi != '0 && hi != '1) return p[2*IZH_N-1] ? FX_MIN : FX_MAX;
    return fx_t'(p[IZH_N-1:0]);
  endfunction

  fx_t w_dv_sum;
  fx_t w_v_tmp;
  fx_t w_dw_sum;
  fx_t w_w_tmp;

  // dv = 0.04 v^2 + 5 v + 140 - w + I ; dw = a (b v - w)
  always_comb begin
    w_dv_sum = sat_add(sat_mul(K_0P04, sat_mul(i_v, i_v)), sat_mul(K_5, i_v));
    w_dv_sum = sat_add(w_dv_sum, K_140);
    w_dv_sum = sat_sub(w_dv_sum, i_w);
    w_dv_sum = sat_add(w_dv_sum, i_cur);
    w_v_tmp  = sat_add(i_v, w_dv_sum >>> DT_SHIFT);

    w_dw_sum = sat_mul(i_a, sat_sub(sat_mul(i_b, i_v), i_w));
    w_w_tmp  = sat_add(i_w, w_dw_sum >>> DT_SHIFT);

    o_fire_c  = (w_v_tmp > V_TH);
    o_v_new_c = o_fire_c ? i_c : w_v_tmp;
    o_w_new_c = o_fire_c ? sat_add(i_w, i_d) : w_w_tmp;
  end

endmodule

// File: rtl/izh_neuron_array.sv
// Time-multiplexed array of Izhikevich neurons sharing one update datapath.
// Each start runs one Euler step for every neuron in index order.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   start                      begin a sweep (only honoured in IDLE)
//   i_rd, i_idx, i_data        current fetch: data valid the cycle after i_rd
//   spike_valid/idx/ready      spike event handshake
//   busy, done, step_cnt       sweep status and completed-sweep count
// Optional feature macro IZH_PARAM_WRITE_EN: adds cfg_we/cfg_idx/cfg_sel/
// cfg_data and per-neuron a/b/c/d registers; otherwise a/b/c/d are constants.
module izh_neuron_array
  import izh_pkg::*;
#(
  parameter int unsigned         N           = IZH_N,
  parameter int unsigned         FRAC        = IZH_FRAC,
  parameter int unsigned         NUM_NEURONS = 8,
  parameter int unsigned         DT_SHIFT    = 3,
  parameter logic signed [N-1:0] V_TH        = N'(32 << FRAC)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  output logic                           i_rd,
  output logic [$clog2(NUM_NEURONS)-1:0] i_idx,
  input  logic [N-1:0]                   i_data,
  output logic                           spike_valid,
  output logic [$clog2(NUM_NEURONS)-1:0] spike_idx,
  input  logic                           spike_ready,
  output logic                           busy,
  output logic                           done,
`ifdef IZH_PARAM_WRITE_EN
  input  logic                           cfg_we,
  input  logic [$clog2(NUM_NEURONS)-1:0] cfg_idx,
  input  logic [1:0]                     cfg_sel,
  input  logic [N-1:0]                   cfg_data,
`endif
  output logic [15:0]                    step_cnt
);

  localparam int unsigned        IDX_W    = $clog2(NUM_NEURONS);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_NEURONS - 1);

  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] r_spike_idx;
  logic             r_i_rd;
  logic             r_spike_valid;
  logic             r_busy;
  logic             r_done;
  logic [15:0]      r_step_cnt;
  fx_t              r_cur;
  fx_t              r_v [NUM_NEURONS];
  fx_t              r_w [NUM_NEURONS];

  fx_t  w_a, w_b, w_c, w_d;
  fx_t  w_v_new, w_w_new;
  logic w_fire;
  logic w_advance;

`ifdef IZH_PARAM_WRITE_EN
  fx_t r_a [NUM_NEURONS];
  fx_t r_b [NUM_NEURONS];
  fx_t r_c [NUM_NEURONS];
  fx_t r_d [NUM_NEURONS];

  // Per-neuron parameter file; frozen while a sweep is running
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        r_a[i] <= A_DEF;
        r_b[i] <= B_DEF;
        r_c[i] <= C_DEF;
        r_d[i] <= D_DEF;
      end
    end else if (cfg_we && !r_busy) begin
      case (cfg_sel)
        2'd0:    r_a[cfg_idx] <= fx_t'(cfg_data);
        2'd1:    r_b[cfg_idx] <= fx_t'(cfg_data);
        2'd2:    r_c[cfg_idx] <= fx_t'(cfg_data);
        default: r_d[cfg_idx] <= fx_t'(cfg_data);
      endcase
    end
  end

  assign w_a = r_a[r_idx];
  assign w_b = r_b[r_idx];
  assign w_c = r_c[r_idx];
  assign w_d = r_d[r_idx];
`else
  assign w_a = A_DEF;
  assign w_b = B_DEF;
  assign w_c = C_DEF;
  assign w_d = D_DEF;
`endif

  izh_datapath #(
    .DT_SHIFT (DT_SHIFT),
    .V_TH     (V_TH)
  ) u_datapath (
    .i_v       (r_v[r_idx]),
    .i_w       (r_w[r_idx]),
    .i_cur     (r_cur),
    .i_a       (w_a),
    .i_b       (w_b),
    .i_c       (w_c),
    .i_d       (w_d),
    .o_v_new_c (w_v_new),
    .o_w_new_c (w_w_new),
    .o_fire_c  (w_fire)
  );

  // Leave the current neuron: after a quiet update or an accepted spike
  assign w_advance = (r_state == S_UPDATE && !w_fire) ||
                     (r_state == S_EMIT && spike_ready);

  // Sweep sequencer with registered outputs and the v/w register file
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_idx         <= '0;
      r_spike_idx   <= '0;
      r_i_rd        <= 1'b0;
      r_spike_valid <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_step_cnt    <= '0;
      r_cur         <= '0;
      for (int i = 0; i < NUM_NEURONS; i++) begin
        r_v[i] <= V_RST;
        r_w[i] <= W_RST;
      end
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_idx   <= '0;
            r_i_rd  <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= S_READ;
          end
        end
        S_READ: begin
          r_i_rd  <= 1'b0;
          r_state <= S_CALC;
        end
        S_CALC: begin
          r_cur   <= fx_t'(i_data);
          r_state <= S_UPDATE;
        end
        S_UPDATE: begin
          r_v[r_idx] <= w_v_new;
          r_w[r_idx] <= w_w_new;
          if (w_fire) begin
            r_spike_valid <= 1'b1;
            r_spike_idx   <= r_idx;
            r_state       <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (spike_ready) r_spike_valid <= 1'b0;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase

      if (w_advance) begin
        if (r_idx == LAST_IDX) begin
          r_state    <= S_DONE;
          r_busy     <= 1'b0;
          r_done     <= 1'b1;
          r_step_cnt <= r_step_cnt + 16'd1;
        end else begin
          r_idx   <= r_idx + IDX_W'(1);
          r_i_rd  <= 1'b1;
          r_state <= S_READ;
        end
      end
    end
  end

  assign i_rd        = r_i_rd;
  assign i_idx       = r_idx;
  assign spike_valid = r_spike_valid;
  assign spike_idx   = r_spike_idx;
  assign busy        = r_busy;
  assign done        = r_done;
  assign step_cnt    = r_step_cnt;

endmodule

// File: tb/tb_izh_neuron_array.sv
// Self-checking bench for izh_neuron_array (4 neurons) against an integer
// reference model of the Euler step with clamped fixed-point arithmetic.
// Build with IZH_PARAM_WRITE_EN to also exercise the parameter write port.
module tb_izh_neuron_array;

  localparam int     NN  = 4;
  localparam int     IW  = $clog2(NN);
  localparam longint ONE = 65536;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          spike_ready = 1'b1;
  logic [31:0]   i_data = '0;
  logic          i_rd;
  logic [IW-1:0] i_idx;
  logic          spike_valid;
  logic [IW-1:0] spike_idx;
  logic          busy;
  logic          done;
  logic [15:0]   step_cnt;
`ifdef IZH_PARAM_WRITE_EN
  logic          cfg_we = 1'b0;
  logic [IW-1:0] cfg_idx = '0;
  logic [1:0]    cfg_sel = '0;
  logic [31:0]   cfg_data = '0;
`endif

  izh_neuron_array #(.NUM_NEURONS(NN)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .i_rd        (i_rd),
    .i_idx       (i_idx),
    .i_data      (i_data),
    .spike_valid (spike_valid),
    .spike_idx   (spike_idx),
    .spike_ready (spike_ready),
    .busy        (busy),
    .done        (done),
`ifdef IZH_PARAM_WRITE_EN
    .cfg_we      (cfg_we),
    .cfg_idx     (cfg_idx),
    .cfg_sel     (cfg_sel),
    .cfg_data    (cfg_data),
`endif
    .step_cnt    (step_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Current source: answers a read request one cycle later
  longint cur_mem [NN];
  always @(posedge clk) if (i_rd) i_data <= 32'(cur_mem[i_idx]);

  // Reference model state
  longint mv [NN], mw [NN], ma [NN], mb [NN], mc [NN], md [NN];
  int     m_steps;
  int     exp_q[$];
  int     got_q[$];
  int     sweep_cycles, hold_cycles, hold_bad;

  function automatic longint clamp(input longint x);
    if (x > 64'sd2147483647) return 64'sd2147483647;
    if (x < -64'sd2147483648) return -64'sd2147483648;
    return x;
  endfunction

  // Real-valued product scaled by 2^-16, rounded toward -inf, clamped
  function automatic longint fmul(input longint a, input longint b);
    return clamp((a * b) >>> 16);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NN; k++) begin
      mv[k] = -65 * ONE; mw[k] = -13 * ONE;
      ma[k] = 1311; mb[k] = 13107; mc[k] = -65 * ONE; md[k] = 5 * ONE;
    end
    m_steps = 0;
  endtask

  // One sweep of the model; fills exp_q with firing indices in order
  task automatic model_sweep();
    longint v, w, t, vt, wt;
    exp_q.delete();
    for (int k = 0; k < NN; k++) begin
      v  = mv[k];
      w  = mw[k];
      t  = clamp(fmul(2621, fmul(v, v)) + fmul(5 * ONE, v));
      t  = clamp(t + 140 * ONE);
      t  = clamp(t - w);
      t  = clamp(t + cur_mem[k]);
      vt = clamp(v + (t >>> 3));
      wt = clamp(w + (fmul(ma[k], clamp(fmul(mb[k], v) - w)) >>> 3));
      if (vt > 32 * ONE) begin
        mv[k] = mc[k];
        mw[k] = clamp(w + md[k]);
        exp_q.push_back(k);
      end else begin
        mv[k] = vt;
        mw[k] = wt;
      end
    end
    m_steps = (m_steps + 1) % 65536;
  endtask

  function automatic int exp_cycles(input int stall);
    return 3 * NN + 1 + exp_q.size() + ((exp_q.size() > 0) ? stall : 0);
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    spike_ready = 1'b1;
`ifdef IZH_PARAM_WRITE_EN
    cfg_we = 1'b0;
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    model_reset();
  endtask

  // Runs one sweep; holds spike_ready low for `stall` cycles on the first
  // spike and pulses start again at cycle `pulse_at` (0 = never).
  task automatic run_sweep(input int stall, input int pulse_at);
    got_q.delete();
    sweep_cycles = -1;
    hold_cycles  = 0;
    hold_bad     = 0;
    spike_ready  = (stall == 0);
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      start = (c == pulse_at);
      if (spike_valid) begin
        if (!spike_ready) begin
          if (hold_cycles == stall) spike_ready = 1'b1;
          else begin
            hold_cycles++;
            if (exp_q.size() == 0 || int'(spike_idx) != exp_q[0]) hold_bad++;
          end
        end
        if (spike_ready) got_q.push_back(int'(spike_idx));
      end
      if (done) begin
        sweep_cycles = c;
        break;
      end
    end
    start = 1'b0;
    spike_ready = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if ({i_rd, spike_valid, busy, done} !== 4'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b want 0000", {i_rd, spike_valid, busy, done});
    end
    n_tests++;
    if ({i_idx, spike_idx, step_cnt} !== '0) begin
      n_fail++; $display("FAIL reset_counts: idx %0d sidx %0d step %0d want 0", i_idx, spike_idx, step_cnt);
    end
    for (int k = 0; k < NN; k++) begin
      n_tests++;
      if (dut.r_v[k] !== 32'hFFBF_0000 || dut.r_w[k] !== 32'hFFF3_0000) begin
        n_fail++; $display("FAIL reset_vw[%0d]: got %h/%h want ffbf0000/fff30000", k, dut.r_v[k], dut.r_w[k]);
      end
    end
  endtask

  task automatic test_quiet();
    do_reset();
    for (int k = 0; k < NN; k++) cur_mem[k] = 0;
    model_sweep();
    run_sweep(0, 0);
    n_tests++;
    if (sweep_cycles != 13) begin
      n_fail++; $display("FAIL quiet_cycles: got %0d want 13", sweep_cycles);
    end
    n_tests++;
    if (got_q.size() != 0 || busy !== 1'b0 || step_cnt !== 16'd1) begin
      n_fail++; $display("FAIL quiet_status: spikes %0d busy %b step %0d want 0/0/1", got_q.size(), busy, step_cnt);
    end
    for (int k = 0; k < NN; k++) begin
      n_tests++;
      if (dut.r_v[k] !== 32'(mv[k]) || dut.r_w[k] !== 32'(mw[k])) begin
        n_fail++; $display("FAIL quiet_vw[%0d]: got %h/%h want %h/%h", k, dut.r_v[k], dut.r_w[k], 32'(mv[k]), 32'(mw[k]));
      end
    end
    @(negedge clk);
    n_tests++;
    if (done !== 1'b0) begin
      n_fail++; $display("FAIL quiet_done_pulse: got %b want 0", done);
    end
  endtask

  task automatic test_spike(input int stall);
    do_reset();
    for (int k = 0; k < NN; k++) cur_mem[k] = 0;
    cur_mem[2] = 4000 * ONE;
    model_sweep();
    run_sweep(stall, 0);
    n_tests++;
    if (sweep_cycles != 14 + stall) begin
      n_fail++; $display("FAIL spike_cycles(stall %0d): got %0d want %0d", stall, sweep_cycles, 14 + stall);
    end
    n_tests++;
    if (got_q.size() != 1 || (got_q.size() == 1 && got_q[0] != 2)) begin
      n_fail++; $display("FAIL spike_idx: got %0d spikes first %0d want 1 spike idx 2",
                         got_q.size(), (got_q.size() > 0) ? got_q[0] : -1);
    end
    n_tests++;
    if (dut.r_v[2] !== 32'hFFBF_0000 || dut.r_w[2] !== 32'hFFF8_0000) begin
      n_fail++; $display("FAIL spike_post_vw: got %h/%h want ffbf0000/fff80000", dut.r_v[2], dut.r_w[2]);
    end
    if (stall > 0) begin
      n_tests++;
      if (hold_cycles != stall || hold_bad != 0) begin
        n_fail++; $display("FAIL spike_hold: held %0d bad %0d want %0d/0", hold_cycles, hold_bad, stall);
      end
    end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int k = 0; k < NN; k++) cur_mem[k] = 0;
    cur_mem[1] = 64'sd2147483647;
    cur_mem[3] = -64'sd2147483648;
    for (int s = 0; s < 2; s++) begin
      model_sweep();
      run_sweep(0, 0);
      n_tests++;
      if (got_q != exp_q || sweep_cycles != exp_cycles(0)) begin
        n_fail++; $display("FAIL sat_spikes[%0d]: got %0d spikes %0d cycles want %0d/%0d",
                           s, got_q.size(), sweep_cycles, exp_q.size(), exp_cycles(0));
      end
      for (int k = 0; k < NN; k++) begin
        n_tests++;
        if (dut.r_v[k] !== 32'(mv[k]) || dut.r_w[k] !== 32'(mw[k])) begin
          n_fail++; $display("FAIL sat_vw[%0d][%0d]: got %h/%h want %h/%h", s, k, dut.r_v[k], dut.r_w[k], 32'(mv[k]), 32'(mw[k]));
        end
      end
    end
    n_tests++;
    if (exp_q.size() == 0 || exp_q[0] != 1 || got_q.size() == 0 || got_q[0] != 1) begin
      n_fail++; $display("FAIL sat_fire: got first spike %0d want 1", (got_q.size() > 0) ? got_q[0] : -1);
    end
  endtask

  task automatic test_back_to_back();
    int stall;
    do_reset();
    for (int s = 0; s < 8; s++) begin
      for (int k = 0; k < NN; k++) begin
        case ($urandom_range(0, 9))
          0:       cur_mem[k] = 64'sd2147483647;
          1:       cur_mem[k] = -64'sd2147483648;
          2:       cur_mem[k] = longint'($signed($urandom()));
          default: cur_mem[k] = longint'($urandom_range(0, 40 * 65536)) - 10 * ONE;
        endcase
      end
      stall = $urandom_range(0, 3);
      model_sweep();
      run_sweep(stall, 0);
      n_tests++;
      if (got_q != exp_q || sweep_cycles != exp_cycles(stall)) begin
        n_fail++; $display("FAIL b2b_sweep[%0d]: got %0d spikes %0d cycles want %0d/%0d",
                           s, got_q.size(), sweep_cycles, exp_q.size(), exp_cycles(stall));
      end
      n_tests++;
      if (step_cnt !== 16'(m_steps)) begin
        n_fail++; $display("FAIL b2b_step[%0d]: got %0d want %0d", s, step_cnt, m_steps);
      end
      for (int k = 0; k < NN; k++) begin
        n_tests++;
        if (dut.r_v[k] !== 32'(mv[k]) || dut.r_w[k] !== 32'(mw[k])) begin
          n_fail++; $display("FAIL b2b_vw[%0d][%0d]: got %h/%h want %h/%h", s, k, dut.r_v[k], dut.r_w[k], 32'(mv[k]), 32'(mw[k]));
        end
      end
    end
  endtask

  task automatic test_start_ignored();
    do_reset();
    for (int k = 0; k < NN; k++) cur_mem[k] = 0;
    model_sweep();
    run_sweep(0, 5);
    n_tests++;
    if (sweep_cycles != 13) begin
      n_fail++; $display("FAIL ign_cycles: got %0d want 13", sweep_cycles);
    end
    repeat (4) @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || step_cnt !== 16'd1) begin
      n_fail++; $display("FAIL ign_after: busy %b step %0d want 0/1", busy, step_cnt);
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < NN; k++) cur_mem[k] = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    n_tests++;
    if (busy !== 1'b1 || i_idx !== IW'(1)) begin
      n_fail++; $display("FAIL mid_precond: busy %b idx %0d want 1/1", busy, i_idx);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({i_rd, spike_valid, busy, done} !== 4'b0 || step_cnt !== 16'd0) begin
      n_fail++; $display("FAIL mid_outputs: flags %b step %0d want 0000/0", {i_rd, spike_valid, busy, done}, step_cnt);
    end
    for (int k = 0; k < NN; k++) begin
      n_tests++;
      if (dut.r_v[k] !== 32'hFFBF_0000 || dut.r_w[k] !== 32'hFFF3_0000) begin
        n_fail++; $display("FAIL mid_vw[%0d]: got %h/%h want ffbf0000/fff30000", k, dut.r_v[k], dut.r_w[k]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

`ifdef IZH_PARAM_WRITE_EN
  task automatic test_cfg();
    do_reset();
    @(negedge clk);
    cfg_we = 1'b1; cfg_idx = '0; cfg_sel = 2'd3; cfg_data = 32'h0008_0000;
    @(negedge clk);
    cfg_we = 1'b0;
    md[0] = 8 * ONE;
    for (int k = 0; k < NN; k++) cur_mem[k] = 0;
    cur_mem[0] = 4000 * ONE;
    model_sweep();
    run_sweep(0, 0);
    n_tests++;
    if (dut.r_w[0] !== 32'hFFFB_0000 || got_q != exp_q) begin
      n_fail++; $display("FAIL cfg_d: w0 %h spikes %0d want fffb0000/%0d", dut.r_w[0], got_q.size(), exp_q.size());
    end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_quiet();
    test_spike(0);
    test_spike(5);
    test_saturate();
    test_back_to_back();
    test_start_ignored();
    test_reset_mid();
`ifdef IZH_PARAM_WRITE_EN
    test_cfg();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
